fight_round_controller: RTL

- Upstream of the game state controller; produces the `game_over` level it consumes to leave FIGHT_STATE.
- While the fight is active, it tracks both players' health and a per-round countdown. It scores rounds as best-of-N and declares the match winner.
- Hit events come from the collision/attack logic.

---
 rtl/game_pkg.sv | 39 +++
 rtl/round_timer.sv | 63 ++++++
 rtl/fight_round_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared encodings for the game top level and the fight round
// controller.
//   - game_state_e : top-level game state encodings
//   - fr_state_e   : fight_round_controller FSM encodings
//   - WINNER_*     : match winner codes driven on fight_round_controller.winner
//   - sat_sub      : saturating subtract used for health/damage
//   - sat_inc2     : 2-bit saturating increment used for round scores
package game_pkg;

    typedef enum logic [1:0] {
        MAIN_MENU           = 2'd0,
        CHARACTER_SELECTION = 2'd1,
        FIGHT_STATE         = 2'd2,
        END_STATE           = 2'd3
    } game_state_e;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ROUND_INTRO = 3'd1,
        FIGHTING    = 3'd2,
        ROUND_END   = 3'd3,
        MATCH_OVER  = 3'd4
    } fr_state_e;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    // Damage at or above the remaining health floors at zero instead of wrapping.
    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
        return (b >= a) ? 16'd0 : (a - b);
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] x);
        return (x == 2'd3) ? 2'd3 : (x + 2'd1);
    endfunction

endpackage

// File: rtl/round_timer.sv
// round_timer: per-round countdown. A prescaler divides clk by TICK_DIV while
// enabled; each prescaler wrap decrements the remaining-tick count.
// Only instantiated when ROUND_TIMER_EN is defined.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   load         : reload count with ROUND_TIME_S and clear prescaler (wins over enable)
//   enable       : prescaler runs only while high, otherwise everything holds
//   tick_count   : remaining ticks
//   expired      : single-cycle strobe on the edge where tick_count reaches 0
module round_timer #(
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned ROUND_TIME_S = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    output logic [6:0] tick_count,
    output logic       expired
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    COUNT_INIT = 7'(ROUND_TIME_S);

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    count_q, count_d;
    logic          wrap;

    assign wrap = enable && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (load) begin
            presc_d = '0;
            count_d = COUNT_INIT;
        end else if (enable) begin
            if (wrap) begin
                presc_d = '0;
                if (count_q != 7'd0) count_d = count_q - 7'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= COUNT_INIT;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    // Flag the expiry on the same edge the count lands on zero so the round
    // ends without an extra idle cycle at 0.
    assign expired    = wrap && !load && (count_q <= 7'd1);
    assign tick_count = count_q;

endmodule

// File: rtl/fight_round_controller.sv
// fight_round_controller: tracks both players' health and the round clock
// during a fight, scores rounds best-of-N and raises game_over/winner for the
// game state controller.
// Build option: define ROUND_TIMER_EN to build the round countdown; without it
// round_timer is tied to 0 and rounds end only on KO.
// Ports:
//   clk, reset                    : clock, asynchronous active-low reset
//   fight_active                  : high while the game is in FIGHT_STATE
//   p1_hit_valid/p1_hit_dmg       : P1 hit on P2 and its damage
//   p2_hit_valid/p2_hit_dmg       : P2 hit on P1 and its damage
//   p1_health, p2_health          : current health
//   round_timer                   : remaining ticks in the round
//   p1_rounds, p2_rounds          : round wins (saturate at 3)
//   round_num                     : current round, 1-based (0 when idle)
//   round_active                  : high in FIGHTING
//   round_over                    : one-cycle pulse on ROUND_END entry
//   game_over, winner             : match result, held until fight_active drops
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | waiting for fight_active, outputs at reset values
// ROUND_INTRO | pre-round pause of INTRO_CYCLES, hits ignored
// FIGHTING    | hits applied, round clock running
// ROUND_END   | post-round pause of END_CYCLES, hits ignored
// MATCH_OVER  | game_over high, winner valid
module fight_round_controller
    import game_pkg::*;
#(
    parameter int unsigned MAX_HEALTH    = 100,
    parameter int unsigned HEALTH_W      = 7,
    parameter int unsigned ROUND_TIME_S  = 60,
    parameter int unsigned TICK_DIV      = 100000000,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned INTRO_CYCLES  = 200000000,
    parameter int unsigned END_CYCLES    = 200000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fight_active,
    input  logic                p1_hit_valid,
    input  logic [7:0]          p1_hit_dmg,
    input  logic                p2_hit_valid,
    input  logic [7:0]          p2_hit_dmg,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic [6:0]          round_timer,
    output logic [1:0]          p1_rounds,
    output logic [1:0]          p2_rounds,
    output logic [2:0]          round_num,
    output logic                round_active,
    output logic                round_over,
    output logic                game_over,
    output logic [1:0]          winner
);

    localparam logic [HEALTH_W-1:0] HEALTH_INIT = HEALTH_W'(MAX_HEALTH);
    localparam logic [31:0]         INTRO_LOAD  = 32'(INTRO_CYCLES - 1);
    localparam logic [31:0]         END_LOAD    = 32'(END_CYCLES - 1);

    fr_state_e           state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [HEALTH_W-1:0] p1_health_q, p1_health_d;
    logic [HEALTH_W-1:0] p2_health_q, p2_health_d;
    logic [1:0]          p1_rounds_q, p1_rounds_d;
    logic [1:0]          p2_rounds_q, p2_rounds_d;
    logic [2:0]          round_num_q, round_num_d;
    logic                round_over_q, round_over_d;
    logic [1:0]          winner_q, winner_d;

    logic                timer_load, timer_en, timer_expired;
    logic [6:0]          timer_count;

    logic [HEALTH_W-1:0] p1_next, p2_next;
    logic                ko_p1, ko_p2;
    logic                p1_won, p2_won;

`ifdef ROUND_TIMER_EN
    round_timer #(
        .TICK_DIV     (TICK_DIV),
        .ROUND_TIME_S (ROUND_TIME_S)
    ) u_round_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .enable     (timer_en),
        .tick_count (timer_count),
        .expired    (timer_expired)
    );
`else
    localparam int unsigned unused_timer_cfg = TICK_DIV + ROUND_TIME_S;
    logic unused_timer_ctl;
    assign unused_timer_ctl = timer_load ^ timer_en;
    assign timer_count      = 7'd0;
    assign timer_expired    = 1'b0;
`endif

    // p1 hits damage p2 and vice versa.
    assign p2_next = p1_hit_valid ? HEALTH_W'(sat_sub(16'(p2_health_q), 16'(p1_hit_dmg))) : p2_health_q;
    assign p1_next = p2_hit_valid ? HEALTH_W'(sat_sub(16'(p1_health_q), 16'(p2_hit_dmg))) : p1_health_q;
    assign ko_p1   = (p1_next == '0);
    assign ko_p2   = (p2_next == '0);
    assign p1_won  = (32'(p1_rounds_q) >= ROUNDS_TO_WIN);
    assign p2_won  = (32'(p2_rounds_q) >= ROUNDS_TO_WIN);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        p1_health_d  = p1_health_q;
        p2_health_d  = p2_health_q;
        p1_rounds_d  = p1_rounds_q;
        p2_rounds_d  = p2_rounds_q;
        round_num_d  = round_num_q;
        round_over_d = 1'b0;
        winner_d     = winner_q;
        timer_load   = 1'b0;
        timer_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fight_active) begin
                    state_d     = ROUND_INTRO;
                    cnt_d       = INTRO_LOAD;
                    round_num_d = 3'd1;
                    p1_health_d = HEALTH_INIT;
                    p2_health_d = HEALTH_INIT;
                    p1_rounds_d = 2'd0;
                    p2_rounds_d = 2'd0;
                    timer_load  = 1'b1;
                end
            end
            ROUND_INTRO: begin
                if (cnt_q == 32'd0) state_d = FIGHTING;
                else                cnt_d   = cnt_q - 32'd1;
            end
            FIGHTING: begin
                timer_en    = 1'b1;
                p1_health_d = p1_next;
                p2_health_d = p2_next;
                // KO takes priority over a timeout landing on the same edge.
                if (ko_p1 || ko_p2) begin
                    state_d      = ROUND_END;
                    cnt_d        = END_LOAD;
                    round_over_d = 1'b1;
                    if (ko_p1) p2_rounds_d = sat_inc2(p2_rounds_q);
                    if (ko_p2) p1_rounds_d = sat_inc2(p1_rounds_q);
                end else if (timer_expired) begin
                    state_d      = ROUND_END;
                    cnt_d        = END_LOAD;
                    round_over_d = 1'b1;
                    if (p1_next >= p2_next) p1_rounds_d = sat_inc2(p1_rounds_q);
                    if (p2_next >= p1_next) p2_rounds_d = sat_inc2(p2_rounds_q);
                end
            end
            ROUND_END: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (p1_won || p2_won) begin
                    state_d  = MATCH_OVER;
                    winner_d = (p1_won && p2_won) ? WINNER_DRAW :
                               p1_won             ? WINNER_P1   : WINNER_P2;
                end else begin
                    state_d     = ROUND_INTRO;
                    cnt_d       = INTRO_LOAD;
                    round_num_d = (round_num_q == 3'd7) ? 3'd7 : (round_num_q + 3'd1);
                    p1_health_d = HEALTH_INIT;
                    p2_health_d = HEALTH_INIT;
                    timer_load  = 1'b1;
                end
            end
            MATCH_OVER: begin
            end
            default: state_d = IDLE;
        endcase

        // Leaving FIGHT_STATE aborts whatever is in progress.
        if (!fight_active) begin
            state_d      = IDLE;
            cnt_d        = 32'd0;
            p1_health_d  = HEALTH_INIT;
            p2_health_d  = HEALTH_INIT;
            p1_rounds_d  = 2'd0;
            p2_rounds_d  = 2'd0;
            round_num_d  = 3'd0;
            round_over_d = 1'b0;
            winner_d     = WINNER_NONE;
            timer_load   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 32'd0;
            p1_health_q  <= HEALTH_INIT;
            p2_health_q  <= HEALTH_INIT;
            p1_rounds_q  <= 2'd0;
            p2_rounds_q  <= 2'd0;
            round_num_q  <= 3'd0;
            round_over_q <= 1'b0;
            winner_q     <= WINNER_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p1_health_q  <= p1_health_d;
            p2_health_q  <= p2_health_d;
            p1_rounds_q  <= p1_rounds_d;
            p2_rounds_q  <= p2_rounds_d;
            round_num_q  <= round_num_d;
            round_over_q <= round_over_d;
            winner_q     <= winner_d;
        end
    end

    assign p1_health    = p1_health_q;
    assign p2_health    = p2_health_q;
    assign round_timer  = timer_count;
    assign p1_rounds    = p1_rounds_q;
    assign p2_rounds    = p2_rounds_q;
    assign round_num    = round_num_q;
    assign round_active = (state_q == FIGHTING);
    assign round_over   = round_over_q;
    assign game_over    = (state_q == MATCH_OVER);
    assign winner       = winner_q;

endmodule
